// File: rtl/demux_pkg.sv
// Shared definitions for the 1-to-3 demultiplexer: destination codes,
// slot state encoding and destination count.
package demux_pkg;

  localparam int NUM_DEST = 3;

  localparam logic [1:0] SEL_D0      = 2'd0;
  localparam logic [1:0] SEL_D1      = 2'd1;
  localparam logic [1:0] SEL_D2      = 2'd2;
  localparam logic [1:0] SEL_ILLEGAL = 2'd3;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/demux_slot.sv
// Single-entry output register slot (EMPTY/FULL) with valid/ready handshake.
// A load while the slot drains keeps it FULL, giving one word per cycle.
module demux_slot
  import demux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             can_load
);

  slot_state_t      r_state;
  slot_state_t      w_next_state;
  logic [WIDTH-1:0] r_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      EMPTY: if (load) w_next_state = FULL;
      FULL:  if (out_ready && !load) w_next_state = EMPTY;
      default: w_next_state = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= '0;
    end else if (load) begin
      r_data <= load_data;
    end
  end

  // Room exists if empty, or if the held word leaves on this same edge.
  assign can_load  = (r_state == EMPTY) || out_ready;
  assign out_valid = (r_state == FULL);
  assign out_data  = r_data;

endmodule

// File: rtl/demux_1_3.sv
// 1-to-3 demultiplexer with per-destination register slots and illegal-select
// detection. Per-destination transfer counters exist only with DEMUX_1_3_CNT_EN.
module demux_1_3
  import demux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  output logic [2:0]       out_valid,
  input  logic [2:0]       out_ready,
  output logic [WIDTH-1:0] out_data0,
  output logic [WIDTH-1:0] out_data1,
  output logic [WIDTH-1:0] out_data2,
  output logic             sel_err,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2
);

  logic [NUM_DEST-1:0] w_can_load;
  logic [NUM_DEST-1:0] w_load;
  logic [WIDTH-1:0]    w_data [NUM_DEST];
  logic                w_in_ready;
  logic                r_sel_err;

  // Readiness looks only at the addressed slot; illegal words are always taken.
  always_comb begin
    w_in_ready = 1'b1;
    case (in_sel)
      SEL_D0:  w_in_ready = w_can_load[0];
      SEL_D1:  w_in_ready = w_can_load[1];
      SEL_D2:  w_in_ready = w_can_load[2];
      default: w_in_ready = 1'b1;
    endcase
  end

  assign in_ready = w_in_ready;

  for (genvar k = 0; k < NUM_DEST; k++) begin : g_slot
    assign w_load[k] = in_valid && w_in_ready && (in_sel == 2'(k));

    demux_slot #(
      .WIDTH(WIDTH)
    ) u_slot (
      .clk      (clk),
      .rst      (rst),
      .load     (w_load[k]),
      .load_data(in_data),
      .out_ready(out_ready[k]),
      .out_valid(out_valid[k]),
      .out_data (w_data[k]),
      .can_load (w_can_load[k])
    );
  end

  assign out_data0 = w_data[0];
  assign out_data1 = w_data[1];
  assign out_data2 = w_data[2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sel_err <= 1'b0;
    end else begin
      r_sel_err <= in_valid && (in_sel == SEL_ILLEGAL);
    end
  end

  assign sel_err = r_sel_err;

`ifdef DEMUX_1_3_CNT_EN
  logic [CNT_W-1:0] r_cnt [NUM_DEST];

  for (genvar k = 0; k < NUM_DEST; k++) begin : g_cnt
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_cnt[k] <= '0;
      end else if (out_valid[k] && out_ready[k]) begin
        r_cnt[k] <= r_cnt[k] + 1'b1;
      end
    end
  end

  assign cnt0 = r_cnt[0];
  assign cnt1 = r_cnt[1];
  assign cnt2 = r_cnt[2];
`else
  assign cnt0 = '0;
  assign cnt1 = '0;
  assign cnt2 = '0;
`endif

endmodule

// File: tb/tb_demux_1_3.sv
// Bench for demux_1_3: directed scenarios plus random traffic, all checked
// against a transaction-level model of the three destination slots.
module tb_demux_1_3;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;
  localparam int CNT_MOD = 1 << CNT_W;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_sel;
  logic [2:0]       out_valid;
  logic [2:0]       out_ready;
  logic [WIDTH-1:0] out_data0, out_data1, out_data2;
  logic             sel_err;
  logic [CNT_W-1:0] cnt0, cnt1, cnt2;

  int vectors = 0;
  int miscompares = 0;

  // Model: each destination holds at most one word; counts are completed handoffs.
  bit          m_full [3];
  int unsigned m_word [3];
  int unsigned m_cnt  [3];
  bit          m_err;

  demux_1_3 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel), .out_valid(out_valid),
    .out_ready(out_ready), .out_data0(out_data0), .out_data1(out_data1),
    .out_data2(out_data2), .sel_err(sel_err), .cnt0(cnt0), .cnt1(cnt1),
    .cnt2(cnt2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned exp_cnt(input int k);
`ifdef DEMUX_1_3_CNT_EN
    return m_cnt[k] % CNT_MOD;
`else
    return 0;
`endif
  endfunction

  function automatic logic [31:0] dout(input int k);
    case (k)
      0: return 32'(out_data0);
      1: return 32'(out_data1);
      default: return 32'(out_data2);
    endcase
  endfunction

  function automatic logic [31:0] cout(input int k);
    case (k)
      0: return 32'(cnt0);
      1: return 32'(cnt1);
      default: return 32'(cnt2);
    endcase
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 3; k++) begin
      m_full[k] = 0; m_word[k] = 0; m_cnt[k] = 0;
    end
    m_err = 0;
  endtask

  task automatic check_outputs(input string tag);
    logic [2:0] ev;
    for (int k = 0; k < 3; k++) ev[k] = m_full[k];
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(ev));
    chk({tag, ".sel_err"}, 32'(sel_err), 32'(m_err));
    for (int k = 0; k < 3; k++) begin
      if (m_full[k]) chk($sformatf("%s.out_data%0d", tag, k), dout(k), m_word[k]);
      chk($sformatf("%s.cnt%0d", tag, k), cout(k), exp_cnt(k));
    end
  endtask

  // One cycle: drive inputs just after a rising edge, check, then advance the model.
  task automatic step(input string tag, input bit v, input int sel, input int data,
                      input logic [2:0] ordy);
    bit er;
    bit take;
    in_valid  = v;
    in_sel    = 2'(sel);
    in_data   = WIDTH'(data);
    out_ready = ordy;
    #1;
    er = (sel == 3) ? 1'b1 : (!m_full[sel] || ordy[sel]);
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(er));
    check_outputs(tag);
    take = v && er;
    for (int k = 0; k < 3; k++) begin
      if (m_full[k] && ordy[k]) begin
        m_cnt[k]++;
        m_full[k] = 0;
      end
      if (take && sel == k) begin
        m_full[k] = 1;
        m_word[k] = data % 256;
      end
    end
    m_err = v && (sel == 3);
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    model_clear();
    chk({tag, ".out_valid"}, 32'(out_valid), 32'd0);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s.out_data%0d", tag, k), dout(k), 32'd0);
      chk($sformatf("%s.cnt%0d", tag, k), cout(k), 32'd0);
    end
    chk({tag, ".sel_err"}, 32'(sel_err), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0; in_valid = 0; in_sel = 0; in_data = 0; out_ready = 3'b111;
    model_clear();
    @(posedge clk);
    #1;
    apply_reset("rst0");

    // Single word to destination 1, drained immediately.
    step("single.load", 1, 1, 'hA5, 3'b111);
    step("single.out",  0, 0, 0,    3'b111);
    step("single.done", 0, 0, 0,    3'b111);

    // Destination 0 back-pressure, then simultaneous unload and load.
    step("bp.first",  1, 0, 'h11, 3'b000);
    step("bp.stall",  1, 0, 'h22, 3'b000);
    step("bp.swap",   1, 0, 'h22, 3'b001);
    step("bp.second", 0, 0, 0,    3'b000);

    // Stalled destination 0 must not block destination 2.
    step("byp.load2", 1, 2, 'h44, 3'b000);
    step("byp.hold",  0, 0, 0,    3'b000);
    step("byp.drain", 0, 0, 0,    3'b111);
    step("byp.empty", 0, 0, 0,    3'b111);

    // Illegal select: consumed, flagged for exactly one cycle.
    step("ill.word",  1, 3, 'h3C, 3'b111);
    step("ill.pulse", 0, 0, 0,    3'b111);
    step("ill.clear", 0, 0, 0,    3'b111);

    // Reset while slot 1 holds a word, asserted between edges.
    step("mid.fill",  1, 1, 'h5A, 3'b000);
    step("mid.held",  0, 0, 0,    3'b000);
    apply_reset("mid.rst");
    step("mid.after", 1, 2, 'h77, 3'b000);
    step("mid.got",   0, 0, 0,    3'b100);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      step("rand", 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
           int'($urandom_range(0, 255)), 3'($urandom_range(0, 7)));
    end

    // Counter wrap on destination 2: CNT_MOD + 1 handshakes from zero.
    apply_reset("wrap.rst");
    for (int i = 0; i <= CNT_MOD; i++) step("wrap.push", 1, 2, i, 3'b100);
    step("wrap.last", 0, 0, 0, 3'b100);
    step("wrap.idle", 0, 0, 0, 3'b100);
    chk("wrap.cnt2", 32'(cnt2), exp_cnt(2));
`ifdef DEMUX_1_3_CNT_EN
    chk("wrap.cnt2_is_1", 32'(cnt2), 32'd1);
`else
    chk("wrap.cnt2_is_0", 32'(cnt2), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
